// File: rtl/mult_div_operand_reg_if.sv
// Handshake and data bundle between the mult/div sequencer and the operand/quotient register.
interface mult_div_operand_reg_if #(
  parameter int unsigned WIDTH = 26
);
  logic             load_req;
  logic             ser_valid;
  logic             ser_in;
  logic             start;
  logic             op_div;
  logic             step;
  logic [1:0]       qin;
  logic             abort;
  logic [5:0]       md_tap;
  logic             md_prev;
  logic [4:0]       step_cnt;
  logic             busy;
  logic             ready;
  logic [WIDTH-1:0] result;
  logic             result_valid;

  modport master (
    output load_req, ser_valid, ser_in, start, op_div, step, qin, abort,
    input  md_tap, md_prev, step_cnt, busy, ready, result, result_valid
  );

  modport slave (
    input  load_req, ser_valid, ser_in, start, op_div, step, qin, abort,
    output md_tap, md_prev, step_cnt, busy, ready, result, result_valid
  );
endinterface

// File: rtl/mult_div_operand_reg.sv
// Operand/quotient register: serial capture, 2-bit-per-step multiply retire or
// divide quotient shift-in, and one-cycle hand-off of the finished word.
module mult_div_operand_reg #(
  parameter int unsigned WIDTH = 26
) (
  input logic                   clk,
  input logic                   rst,
  mult_div_operand_reg_if.slave bus
);
  localparam int unsigned STEPS = WIDTH / 2;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned SC_W  = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADING,
    S_READY,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   md_q, md_d;
  logic               md_prev_q, md_prev_d;
  logic [SC_W-1:0]    step_cnt_q, step_cnt_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               op_div_q, op_div_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic               rv_q, rv_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      md_q       <= '0;
      md_prev_q  <= 1'b0;
      step_cnt_q <= '0;
      bit_cnt_q  <= '0;
      op_div_q   <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      rv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      md_q       <= md_d;
      md_prev_q  <= md_prev_d;
      step_cnt_q <= step_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      op_div_q   <= op_div_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      rv_q       <= rv_d;
    end
  end

  // Next-state and datapath update; abort overrides everything below reset
  always_comb begin
    state_d    = state_q;
    md_d       = md_q;
    md_prev_d  = md_prev_q;
    step_cnt_d = step_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    op_div_d   = op_div_q;

    if (bus.abort) begin
      state_d    = S_IDLE;
      md_d       = '0;
      md_prev_d  = 1'b0;
      step_cnt_d = '0;
      bit_cnt_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.load_req) begin
            md_d      = '0;
            bit_cnt_d = '0;
            state_d   = S_LOADING;
          end
        end
        S_LOADING: begin
          if (bus.ser_valid) begin
            md_d      = {bus.ser_in, md_q[WIDTH-1:1]};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(WIDTH - 1)) state_d = S_READY;
          end
        end
        S_READY: begin
          if (bus.start) begin
            op_div_d   = bus.op_div;
            step_cnt_d = '0;
            md_prev_d  = 1'b0;
            state_d    = S_RUN;
          end
        end
        S_RUN: begin
          if (bus.step) begin
            if (op_div_q) begin
              md_d = {md_q[WIDTH-3:0], bus.qin};
            end else begin
              md_prev_d = md_q[1];
              md_d      = {{2{md_q[WIDTH-1]}}, md_q[WIDTH-1:2]};
            end
            step_cnt_d = step_cnt_q + SC_W'(1);
            if (step_cnt_q == SC_W'(STEPS - 1)) state_d = S_DONE;
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // Status flags are registered alongside the state they decode
    busy_d  = (state_d == S_LOADING) || (state_d == S_RUN);
    ready_d = (state_d == S_READY);
    rv_d    = (state_d == S_DONE);
  end

  assign bus.md_tap       = 6'(md_q);
  assign bus.md_prev      = md_prev_q;
  assign bus.step_cnt     = step_cnt_q;
  assign bus.busy         = busy_q;
  assign bus.ready        = ready_q;
  assign bus.result       = md_q;
  assign bus.result_valid = rv_q;
endmodule

// File: tb/tb_mult_div_operand_reg.sv
// Directed bench for mult_div_operand_reg with a result scoreboard.
module tb_mult_div_operand_reg;
  localparam int unsigned W = 26;
  localparam int unsigned STEPS = W / 2;

  logic clk;
  logic rst;
  int   chk_cnt;
  int   pass_cnt;
  int   rv_seen;
  logic [W-1:0] exp_q[$];

  mult_div_operand_reg_if #(.WIDTH(W)) bus ();

  mult_div_operand_reg #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every result pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (bus.result_valid === 1'b1) begin
      rv_seen++;
      if (exp_q.size() == 0) check("unexpected_result_valid", 32'd1, 32'd0);
      else check("result", 32'(bus.result), 32'(exp_q.pop_front()));
    end
  end

  task automatic idle_inputs();
    bus.load_req = 1'b0; bus.ser_valid = 1'b0; bus.ser_in = 1'b0;
    bus.start = 1'b0; bus.op_div = 1'b0; bus.step = 1'b0;
    bus.qin = 2'b00; bus.abort = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_md_tap"}, 32'(bus.md_tap), 32'd0);
    check({tag, "_md_prev"}, 32'(bus.md_prev), 32'd0);
    check({tag, "_step_cnt"}, 32'(bus.step_cnt), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_ready"}, 32'(bus.ready), 32'd0);
    check({tag, "_result"}, 32'(bus.result), 32'd0);
    check({tag, "_rv"}, 32'(bus.result_valid), 32'd0);
  endtask

  task automatic load(input logic [W-1:0] word);
    bus.load_req = 1'b1;
    tick();
    bus.load_req = 1'b0;
    check("load_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < int'(W); i++) begin
      bus.ser_valid = 1'b1;
      bus.ser_in = word[i];
      tick();
      if (i == int'(W) - 2) check("load_not_ready_early", 32'(bus.ready), 32'd0);
    end
    bus.ser_valid = 1'b0;
    check("load_ready", 32'(bus.ready), 32'd1);
    check("load_busy_low", 32'(bus.busy), 32'd0);
    check("load_word", 32'(bus.result), 32'(word));
  endtask

  task automatic run_mul(input logic [W-1:0] op);
    logic [W-1:0] m;
    logic         p;
    int           rv0;
    m = op;
    for (int i = 0; i < int'(STEPS); i++) m = {m[W-1], m[W-1], m[W-1:2]};
    exp_q.push_back(m);
    m = op;
    rv0 = rv_seen;
    bus.op_div = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("mul_run_busy", 32'(bus.busy), 32'd1);
    check("mul_tap0", 32'(bus.md_tap), 32'(m[5:0]));
    for (int s = 0; s < int'(STEPS); s++) begin
      bus.step = 1'b1;
      tick();
      bus.step = 1'b0;
      p = m[1];
      m = {m[W-1], m[W-1], m[W-1:2]};
      check("mul_tap", 32'(bus.md_tap), 32'(m[5:0]));
      check("mul_prev", 32'(bus.md_prev), 32'(p));
      check("mul_step_cnt", 32'(bus.step_cnt), 32'(s + 1));
      check("mul_rv_timing", 32'(bus.result_valid), (s == int'(STEPS) - 1) ? 32'd1 : 32'd0);
      tick();
    end
    check("mul_idle_after", 32'({bus.busy, bus.ready, bus.result_valid}), 32'd0);
    check("mul_one_pulse", 32'(rv_seen - rv0), 32'd1);
  endtask

  task automatic run_div(input logic [1:0] q);
    logic [W-1:0] m;
    int           rv0;
    m = bus.result;
    for (int i = 0; i < int'(STEPS); i++) m = {m[W-3:0], q};
    exp_q.push_back(m);
    m = bus.result;
    rv0 = rv_seen;
    bus.op_div = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.op_div = 1'b0;
    bus.qin = q;
    bus.step = 1'b1;
    for (int s = 0; s < int'(STEPS); s++) begin
      tick();
      m = {m[W-3:0], q};
      check("div_md", 32'(bus.result), 32'(m));
      check("div_prev", 32'(bus.md_prev), 32'd0);
    end
    bus.step = 1'b0;
    check("div_step_cnt", 32'(bus.step_cnt), STEPS);
    check("div_rv", 32'(bus.result_valid), 32'd1);
    tick();
    check("div_rv_low", 32'(bus.result_valid), 32'd0);
    check("div_one_pulse", 32'(rv_seen - rv0), 32'd1);
  endtask

  initial begin
    logic [W-1:0] r;
    int           rv0;
    chk_cnt = 0; pass_cnt = 0; rv_seen = 0;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Serial capture, and LOAD_REQ in READY is not queued
    load(26'h0000005);
    bus.load_req = 1'b1;
    tick();
    bus.load_req = 1'b0;
    check("load_req_in_ready_ready", 32'(bus.ready), 32'd1);
    check("load_req_in_ready_md", 32'(bus.result), 32'h5);

    run_mul(26'h0000005);

    load(26'h2000000);
    run_mul(26'h2000000);
    check("neg_mul_md_retained", 32'(bus.result), 32'h3FFFFFF);

    r = W'($urandom);
    load(r);
    run_mul(r);

    load(W'($urandom));
    run_div(2'b10);
    check("div_md_retained", 32'(bus.result), 32'h2AAAAAA);

    // Abort after step 6, then STEP/START in IDLE do nothing
    rv0 = rv_seen;
    load(W'($urandom));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int s = 0; s < 6; s++) begin
      bus.step = 1'b1;
      tick();
    end
    bus.step = 1'b0;
    check("pre_abort_step_cnt", 32'(bus.step_cnt), 32'd6);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_all_zero("abort");
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check_all_zero("idle_ignore");

    // Abort coinciding with the final step wins
    load(W'($urandom));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.step = 1'b1;
    for (int s = 0; s < int'(STEPS) - 1; s++) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.step = 1'b0;
    check_all_zero("abort_last_step");
    tick();
    check("abort_no_result", 32'(rv_seen - rv0), 32'd0);

    // Reset in the middle of a load, then a clean reload
    bus.load_req = 1'b1;
    tick();
    bus.load_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.ser_valid = 1'b1;
      bus.ser_in = 1'b1;
      tick();
    end
    bus.ser_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("mid_load_reset");
    tick();
    r = W'($urandom);
    load(r);
    run_mul(r);

    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
